// File: rtl/sram_req_ctrl_16384x32.sv
// sram_req_ctrl_16384x32
//
// Request-side controller for a 16384x32 byte-write SRAM. Requests arrive on a
// valid/ready channel and are driven straight onto the SRAM port in the accept
// cycle. Read data returns one cycle after the read select. It is captured into
// a small in-order response buffer that drains on a valid/ready channel. After
// reset, and whenever clear_start is pulsed, the whole array is zero-filled
// before traffic is served again.
//
// Ports
//   clk                  in   single clock (SRAM is clocked from the same net)
//   reset                in   asynchronous, active-high
//   req_valid/req_ready  in/out request handshake
//   req_read_not_write   in   1 = read, 0 = write
//   req_address          in   word address
//   req_byte_enable      in   write byte enables (ignored on reads)
//   req_write_data       in   write data
//   resp_valid/resp_ready out/in response handshake
//   resp_data            out  read data, in request order
//   clear_start          in   one-cycle pulse requesting a zero-fill
//   clear_busy           out  zero-fill pending or running
//   sram_clock__enable   out  SRAM clock enable, tied high
//   sram_select, sram_read_not_write, sram_write_enable,
//   sram_address, sram_write_data   out  SRAM command port
//   sram_data_in         in   SRAM read data, valid the cycle after a read select
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | writing zero to clear_addr every cycle; no requests accepted
// ST_RUN   | serving requests; pending clear waits for reads to drain

module sram_req_ctrl_16384x32 #(
    parameter int unsigned address_width = 14,
    parameter int unsigned data_width    = 32,
    parameter int unsigned resp_depth    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_read_not_write,
    input  logic [address_width-1:0]  req_address,
    input  logic [data_width/8-1:0]   req_byte_enable,
    input  logic [data_width-1:0]     req_write_data,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [data_width-1:0]     resp_data,
    input  logic                      clear_start,
    output logic                      clear_busy,
    output logic                      sram_clock__enable,
    output logic                      sram_select,
    output logic                      sram_read_not_write,
    output logic [data_width/8-1:0]   sram_write_enable,
    output logic [address_width-1:0]  sram_address,
    output logic [data_width-1:0]     sram_write_data,
    input  logic [data_width-1:0]     sram_data_in
);

    localparam int unsigned ptr_width = $clog2(resp_depth);
    localparam int unsigned cnt_width = $clog2(resp_depth + 1);
    localparam int unsigned occ_width = cnt_width + 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [address_width-1:0]   clear_addr_q, clear_addr_d;
    logic                       clear_pending_q, clear_pending_d;
    logic                       rd_inflight_q, rd_inflight_d;
    logic [data_width-1:0]      buf_q [resp_depth];
    logic [data_width-1:0]      buf_d [resp_depth];
    logic [ptr_width-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ptr_width-1:0]       rd_ptr_q, rd_ptr_d;
    logic [cnt_width-1:0]       count_q, count_d;

    logic                       push;
    logic                       pop;
    logic                       fire;
    logic [occ_width-1:0]       occupancy;

    function automatic logic [ptr_width-1:0] ptr_next(input logic [ptr_width-1:0] p);
        logic [ptr_width-1:0] n;
        if (p == ptr_width'(resp_depth - 1)) begin
            n = '0;
        end else begin
            n = p + 1'b1;
        end
        return n;
    endfunction

    assign sram_clock__enable = 1'b1;
    assign resp_valid         = (count_q != '0);
    assign resp_data          = buf_q[rd_ptr_q];
    assign clear_busy         = (state_q == ST_CLEAR) | clear_pending_q;

    // Credit check: an outstanding read plus buffered entries, less the one
    // leaving this cycle, must leave room for the read about to be accepted.
    always_comb begin
        pop       = resp_valid & resp_ready;
        push      = rd_inflight_q;
        occupancy = occ_width'(count_q) + occ_width'(rd_inflight_q) - occ_width'(pop);
        req_ready = (state_q == ST_RUN) & ~clear_pending_q
                    & (occupancy < occ_width'(resp_depth));
        fire      = req_valid & req_ready;
    end

    always_comb begin
        sram_select         = 1'b0;
        sram_read_not_write = 1'b1;
        sram_write_enable   = '0;
        sram_address        = req_address;
        sram_write_data     = req_write_data;
        case (state_q)
            ST_CLEAR: begin
                // Reset parks the FSM in ST_CLEAR; gating with reset keeps the
                // array untouched while reset is held.
                sram_select         = ~reset;
                sram_read_not_write = 1'b0;
                sram_write_enable   = '1;
                sram_address        = clear_addr_q;
                sram_write_data     = '0;
            end
            ST_RUN: begin
                sram_select         = fire;
                sram_read_not_write = req_read_not_write;
                sram_write_enable   = req_read_not_write ? '0 : req_byte_enable;
            end
            default: begin
                sram_select = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d         = state_q;
        clear_addr_d    = clear_addr_q;
        clear_pending_d = clear_pending_q;
        rd_inflight_d   = fire & req_read_not_write;
        case (state_q)
            ST_CLEAR: begin
                clear_addr_d = clear_addr_q + 1'b1;
                if (clear_addr_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_pending_q && !rd_inflight_q && (count_q == '0)) begin
                    state_d         = ST_CLEAR;
                    clear_pending_d = 1'b0;
                end else if (clear_start) begin
                    clear_pending_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            buf_d[wr_ptr_q] = sram_data_in;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_CLEAR;
            clear_addr_q    <= '0;
            clear_pending_q <= 1'b0;
            rd_inflight_q   <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            for (int i = 0; i < int'(resp_depth); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            clear_addr_q    <= clear_addr_d;
            clear_pending_q <= clear_pending_d;
            rd_inflight_q   <= rd_inflight_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            buf_q           <= buf_d;
        end
    end

endmodule
